// File: rtl/decade_seq_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD decade sequencer.
// Holds the FSM encoding, the BCD digit limit and the default digit count.
package decade_ctrl_pkg;

  localparam int NUM_DIGITS_DEF = 2;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic nib_ok(
    input logic [3:0] n
  );
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/decade_seq_ctrl_if.sv
// Command, configuration and status bundle of the decade sequencer.
// The controller takes the slave side; the bus owner takes the master side.
interface decade_seq_ctrl_if
  import decade_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) ();

  logic                    start;
  logic                    stop;
  logic                    clr;
  logic                    auto_reload;
  logic                    cfg_we;
  logic [4*NUM_DIGITS-1:0] term_bcd;
  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic [1:0]              state;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;

  modport master (
    output start,
    output stop,
    output clr,
    output auto_reload,
    output cfg_we,
    output term_bcd,
    input  count_bcd,
    input  state,
    input  busy,
    input  done,
    input  cfg_err
  );

  modport slave (
    input  start,
    input  stop,
    input  clr,
    input  auto_reload,
    input  cfg_we,
    input  term_bcd,
    output count_bcd,
    output state,
    output busy,
    output done,
    output cfg_err
  );

endinterface

// File: rtl/decade_seq_ctrl_digit.sv
// One synchronous BCD decade digit; steps when enabled and carried into,
// wraps 9 -> 0 and raises carry_out on that wrap.
module bcd_digit
  import decade_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       clr,
  input  logic       en,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic       step;

  assign step = en & carry_in;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (step) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = step & (q_q == BCD_MAX);

endmodule

// File: rtl/decade_seq_ctrl.sv
// Decade sequencer: run/pause/done FSM, terminal register and config check
// driving a carry-chained row of BCD digits.
module decade_seq_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic              clk,
  input  logic              res,
  decade_seq_ctrl_if.slave  bus
);

  localparam int W = 4 * NUM_DIGITS;

  state_e         state_q;
  state_e         state_d;
  logic [W-1:0]   term_q;
  logic [W-1:0]   term_d;
  logic [W-1:0]   cnt;
  logic           done_q;
  logic           done_d;
  logic           err_q;
  logic           err_d;
  logic           busy_q;
  logic           busy_d;
  logic           cnt_clr;
  logic           cnt_en;
  logic           match;
  logic           cfg_open;
  logic           term_ok;
  logic [NUM_DIGITS:0] carry;
  logic           unused_carry;

  assign match    = (cnt == term_q);
  assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

  always_comb begin
    term_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!nib_ok(bus.term_bcd[4*i +: 4])) begin
        term_ok = 1'b0;
      end
    end
  end

  // Writes land only while no count is in flight; anything else is rejected.
  always_comb begin
    term_d = term_q;
    err_d  = 1'b0;
    if (bus.cfg_we) begin
      if (cfg_open && term_ok) begin
        term_d = bus.term_bcd;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    done_d  = 1'b0;
    if (bus.clr) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
        end
        ST_RUN: begin
          // Stop outranks both a pending start and a terminal match.
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (match) begin
            done_d = 1'b1;
            if (bus.auto_reload) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      term_q  <= {NUM_DIGITS{BCD_MAX}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk       (clk),
      .res       (res),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .carry_in  (carry[g]),
      .q         (cnt[4*g +: 4]),
      .carry_out (carry[g+1])
    );
  end

  // The count never passes term, so the top digit's wrap goes nowhere.
  assign unused_carry = carry[NUM_DIGITS];

  assign bus.count_bcd = cnt;
  assign bus.state     = state_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_decade_seq_ctrl.sv
// Directed bench for decade_seq_ctrl with a per-cycle expected-value queue.
// A decimal reference model supplies every expected count/state/done value.
module tb_decade_seq_ctrl;
  import decade_ctrl_pkg::*;

  typedef struct {
    logic [7:0] cnt;
    logic [1:0] st;
    logic       dn;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;

  decade_seq_ctrl_if #(.NUM_DIGITS(2)) bus ();

  decade_seq_ctrl #(.NUM_DIGITS(2)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_cnt  = 8'h00;
  logic [7:0] m_term = 8'h99;
  logic [1:0] m_st   = 2'd0;
  logic       m_ar   = 1'b0;
  int         cyc    = 0;
  int         last_done = -1;
  int         ngap   = 0;
  logic       gap_on = 1'b0;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
    if (d > 99) d = 0;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command-free cycles: model predicts, queue holds, DUT output is popped.
  task automatic free_run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dn = 1'b0;
      if (m_st == 2'd1) begin
        if (m_cnt == m_term) begin
          e.dn = 1'b1;
          if (m_ar) m_cnt = 8'h00;
          else m_st = 2'd3;
        end else begin
          m_cnt = bcd_inc(m_cnt);
        end
      end
      e.cnt = m_cnt;
      e.st  = m_st;
      sbq.push_back(e);
      tick();
      cyc++;
      e = sbq.pop_front();
      chk("count", bus.count_bcd, e.cnt);
      chk("state", bus.state, e.st);
      chk("done", bus.done, e.dn);
      if (gap_on && bus.done) begin
        if (last_done >= 0) begin
          ngap++;
          chk("done_gap", cyc - last_done, 100);
        end
        last_done = cyc;
      end
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_st  = 2'd1;
    m_cnt = 8'h00;
    chk("start_count", bus.count_bcd, 8'h00);
    chk("start_state", bus.state, ST_RUN);
    chk("start_done", bus.done, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] t);
    bus.cfg_we   = 1'b1;
    bus.term_bcd = t;
    free_run(1);
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clr         = 1'b0;
    bus.auto_reload = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.term_bcd    = 8'h00;

    tick();
    tick();
    chk("rst_state", bus.state, ST_IDLE);
    chk("rst_count", bus.count_bcd, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_cfg_err", bus.cfg_err, 1'b0);
    res = 1'b0;

    // Default term of 99, one-shot
    do_start();
    chk("run_busy", bus.busy, 1'b1);
    free_run(100);
    chk("done_busy", bus.busy, 1'b0);
    free_run(1);

    // term 12 one-shot, written in DONE
    cfg(8'h12);
    chk("cfg12_err", bus.cfg_err, 1'b0);
    m_term = 8'h12;
    do_start();
    free_run(14);
    chk("t12_hold", bus.count_bcd, 8'h12);

    // term 0: done on the edge after the start edge
    cfg(8'h00);
    m_term = 8'h00;
    do_start();
    free_run(2);

    // term 99 with auto reload, done spacing
    cfg(8'h99);
    m_term = 8'h99;
    bus.auto_reload = 1'b1;
    m_ar = 1'b1;
    do_start();
    gap_on = 1'b1;
    last_done = -1;
    free_run(210);
    gap_on = 1'b0;
    chk("gap_count", ngap, 1);
    for (int k = 0; k < 200 && m_cnt != 8'h37; k++) free_run(1);

    // Pause at 37, resume, start+stop together
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    m_st = 2'd2;
    chk("pause_state", bus.state, ST_PAUSE);
    chk("pause_count", bus.count_bcd, 8'h37);
    chk("pause_busy", bus.busy, 1'b1);
    free_run(5);
    bus.stop = 1'b1;
    free_run(1);
    bus.stop = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_st = 2'd1;
    chk("resume_count", bus.count_bcd, 8'h37);
    chk("resume_state", bus.state, ST_RUN);
    free_run(1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    m_st = 2'd2;
    chk("ss_state", bus.state, ST_PAUSE);
    chk("ss_count", bus.count_bcd, 8'h38);

    // Config write while running is rejected
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_st = 2'd1;
    chk("resume2_count", bus.count_bcd, 8'h38);
    cfg(8'h05);
    chk("run_cfg_err", bus.cfg_err, 1'b1);
    free_run(1);
    chk("run_cfg_err_end", bus.cfg_err, 1'b0);

    // clr at 44
    for (int k = 0; k < 200 && m_cnt != 8'h44; k++) free_run(1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    m_st  = 2'd0;
    m_cnt = 8'h00;
    chk("clr_state", bus.state, ST_IDLE);
    chk("clr_count", bus.count_bcd, 8'h00);
    chk("clr_done", bus.done, 1'b0);
    chk("clr_busy", bus.busy, 1'b0);
    free_run(2);

    // IDLE writes: 15 accepted, 1A rejected
    cfg(8'h15);
    chk("cfg15_err", bus.cfg_err, 1'b0);
    m_term = 8'h15;
    cfg(8'h1A);
    chk("cfg1a_err", bus.cfg_err, 1'b1);
    bus.auto_reload = 1'b0;
    m_ar = 1'b0;
    do_start();
    free_run(16);
    chk("t15_state", bus.state, ST_DONE);
    chk("t15_count", bus.count_bcd, 8'h15);

    // res at 20
    cfg(8'h30);
    m_term = 8'h30;
    do_start();
    for (int k = 0; k < 200 && m_cnt != 8'h20; k++) free_run(1);
    res = 1'b1;
    tick();
    res = 1'b0;
    m_st   = 2'd0;
    m_cnt  = 8'h00;
    m_term = 8'h99;
    chk("res_state", bus.state, ST_IDLE);
    chk("res_count", bus.count_bcd, 8'h00);
    chk("res_done", bus.done, 1'b0);
    chk("res_busy", bus.busy, 1'b0);
    free_run(1);

    // Stop wins over a terminal match
    cfg(8'h00);
    m_term = 8'h00;
    do_start();
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    m_st = 2'd2;
    chk("stopm_state", bus.state, ST_PAUSE);
    chk("stopm_done", bus.done, 1'b0);
    chk("stopm_count", bus.count_bcd, 8'h00);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("final_state", bus.state, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
